// File: rtl/hpi_txn_sequencer.sv
// hpi_txn_sequencer: two-port HPI transaction sequencer with programmable strobe/hold timing.
// Define HPI_ARB_RR_EN for round-robin arbitration; otherwise port 0 has fixed priority.
module hpi_txn_sequencer #(
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [1:0]  addr0,
    input  logic [1:0]  addr1,
    input  logic [15:0] wdata0,
    input  logic [15:0] wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        gnt,
    output logic [1:0]  hpi_address,
    output logic [15:0] hpi_data_out,
    output logic        hpi_r,
    output logic        hpi_w,
    output logic        hpi_cs,
    input  logic [15:0] hpi_data_in
);
    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, DONE} state_t;
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic we, win, grant;
    assign grant = (state == IDLE) && (req0 || req1);
`ifdef HPI_ARB_RR_EN
    logic rr;
    assign win = (req0 && req1) ? rr : req1;
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) rr <= 1'b0;
        else if (grant) rr <= !win;
    end
`else
    assign win = !req0;
`endif
    always_comb begin
        state_nxt = state;
        cnt_nxt = (cnt != 4'd0) ? cnt - 4'd1 : cnt;
        case (state)
            IDLE:   state_nxt = grant ? SETUP : IDLE;
            SETUP: begin
                state_nxt = STROBE;
                cnt_nxt = STROBE_LD;
            end
            STROBE: if (cnt == 4'd0) begin
                state_nxt = HOLD;
                cnt_nxt = HOLD_LD;
            end
            HOLD:   state_nxt = (cnt == 4'd0) ? DONE : HOLD;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end
    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            cnt <= 4'd0;
            hpi_cs <= 1'b1;
            hpi_r <= 1'b1;
            hpi_w <= 1'b1;
            hpi_address <= 2'd0;
            hpi_data_out <= 16'd0;
            we <= 1'b0;
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            rdata <= 16'd0;
            busy <= 1'b0;
            gnt <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt <= cnt_nxt;
            hpi_cs <= (state_nxt == IDLE) || (state_nxt == DONE);
            hpi_r <= !((state_nxt == STROBE) && !we);
            hpi_w <= !((state_nxt == STROBE) && we);
            busy <= state_nxt != IDLE;
            ack0 <= (state_nxt == DONE) && !gnt;
            ack1 <= (state_nxt == DONE) && gnt;
            if (grant) begin
                gnt <= win;
                we <= win ? we1 : we0;
                hpi_address <= win ? addr1 : addr0;
                hpi_data_out <= win ? wdata1 : wdata0;
            end
            // Pad data lags the strobe by the pad register stages; first HOLD cycle still reflects the read.
            if ((state == HOLD) && (cnt == HOLD_LD) && !we) rdata <= hpi_data_in;
        end
    end
endmodule

// File: tb/tb_hpi_txn_sequencer.sv
// tb_hpi_txn_sequencer: self-checking bench for hpi_txn_sequencer at three timing configurations.
// Instance 0 uses the defaults (2,2); instances 1 and 2 use (1,2) and (15,15).
module tb_hpi_txn_sequencer;
    localparam int N = 3;
    logic Clk = 1'b0;
    logic Reset = 1'b1;
    logic req0 [N], req1 [N], we0 [N], we1 [N];
    logic ack0 [N], ack1 [N], busy [N], gnt [N], hpi_r [N], hpi_w [N], hpi_cs [N];
    logic [1:0] addr0 [N], addr1 [N], hpi_address [N];
    logic [15:0] wdata0 [N], wdata1 [N], rdata [N], hpi_data_out [N], hpi_data_in [N];
    logic [15:0] exp_rdata [N];
    int last [N];
    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < N; g++) begin : g_dut
        hpi_txn_sequencer #(
            .STROBE_CYC(g == 0 ? 2 : g == 1 ? 1 : 15),
            .HOLD_CYC(g == 0 ? 2 : g == 1 ? 2 : 15)
        ) dut (
            .Clk(Clk), .Reset(Reset),
            .req0(req0[g]), .req1(req1[g]), .we0(we0[g]), .we1(we1[g]),
            .addr0(addr0[g]), .addr1(addr1[g]), .wdata0(wdata0[g]), .wdata1(wdata1[g]),
            .ack0(ack0[g]), .ack1(ack1[g]), .rdata(rdata[g]), .busy(busy[g]), .gnt(gnt[g]),
            .hpi_address(hpi_address[g]), .hpi_data_out(hpi_data_out[g]),
            .hpi_r(hpi_r[g]), .hpi_w(hpi_w[g]), .hpi_cs(hpi_cs[g]), .hpi_data_in(hpi_data_in[g])
        );
    end

    function automatic int s_of(input int k);
        return k == 0 ? 2 : k == 1 ? 1 : 15;
    endfunction

    function automatic int h_of(input int k);
        return k == 2 ? 15 : 2;
    endfunction

    // Winner by the arbitration rule: with both pending, RR favours the port not granted last.
    function automatic int pick(input int k);
`ifdef HPI_ARB_RR_EN
        if (req0[k] && req1[k]) return last[k] == 0 ? 1 : 0;
`else
        if (req0[k] && req1[k]) return 0;
`endif
        return req1[k] ? 1 : 0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Follows one transaction from grant to ack on instance k and checks it against the timing rules.
    task automatic txn(input int k, input bit hold_req, input int drop_at, input bit fix_din);
        int s = s_of(k);
        int h = h_of(k);
        int exp, n = 0, cs_n = 0, r_n = 0, w_n = 0, t = 0, port = -1;
        bit we, stable = 1'b1;
        logic [1:0] a;
        logic [15:0] d, cap = 16'h0, exp_a_d;
        exp = pick(k);
        we = exp == 1 ? we1[k] : we0[k];
        do begin
            @(negedge Clk);
            t++;
        end while (!busy[k] && t < 100);
        a = hpi_address[k];
        d = hpi_data_out[k];
        while (busy[k] && port < 0 && n < 64) begin
            n++;
            if (!hpi_cs[k]) cs_n++;
            if (!hpi_r[k]) r_n++;
            if (!hpi_w[k]) w_n++;
            if (hpi_address[k] !== a || hpi_data_out[k] !== d) stable = 1'b0;
            if (ack0[k] || ack1[k]) port = ack1[k] ? 1 : 0;
            else begin
                if (!fix_din) hpi_data_in[k] = 16'($urandom);
                if (n == s + 2) cap = hpi_data_in[k];
                if (n == drop_at) begin
                    req0[k] = 1'b0;
                    req1[k] = 1'b0;
                end
                @(negedge Clk);
            end
        end
        chk("ack_port", port, exp);
        chk("gnt", gnt[k], exp);
        chk("txn_len", n + 1, 3 + s + h);
        chk("cs_low", cs_n, s + h + 1);
        chk("r_low", r_n, we ? 0 : s);
        chk("w_low", w_n, we ? s : 0);
        chk("bus_stable", stable, 1);
        chk("address", a, exp == 1 ? addr1[k] : addr0[k]);
        exp_a_d = exp == 1 ? wdata1[k] : wdata0[k];
        chk("data_out", d, exp_a_d);
        if (!we) exp_rdata[k] = cap;
        chk("rdata", rdata[k], exp_rdata[k]);
        last[k] = exp;
        if (!hold_req) begin
            if (port == 0) req0[k] = 1'b0;
            if (port == 1) req1[k] = 1'b0;
        end
    endtask

    task automatic rand_txns(input int k, input int cnt);
        for (int i = 0; i < cnt; i++) begin
            int m;
            m = $urandom_range(1, 3);
            we0[k] = 1'($urandom);
            we1[k] = 1'($urandom);
            addr0[k] = 2'($urandom);
            addr1[k] = 2'($urandom);
            wdata0[k] = 16'($urandom);
            wdata1[k] = 16'($urandom);
            req0[k] = m[0];
            req1[k] = m[1];
            for (int j = 0; j < 2 && (req0[k] || req1[k]); j++) txn(k, 1'b0, 0, 1'b0);
            req0[k] = 1'b0;
            req1[k] = 1'b0;
        end
    endtask

    initial begin
        int b;
        for (int k = 0; k < N; k++) begin
            req0[k] = 1'b0; req1[k] = 1'b0; we0[k] = 1'b0; we1[k] = 1'b0;
            addr0[k] = 2'd0; addr1[k] = 2'd0; wdata0[k] = 16'd0; wdata1[k] = 16'd0;
            hpi_data_in[k] = 16'd0; exp_rdata[k] = 16'd0; last[k] = -1;
        end
        repeat (3) @(negedge Clk);
        for (int k = 0; k < N; k++) begin
            chk("reset_ctrl", {hpi_cs[k], hpi_r[k], hpi_w[k], ack0[k], ack1[k], busy[k], gnt[k]}, 7'b1110000);
            chk("reset_bus", {hpi_address[k], hpi_data_out[k]}, 0);
            chk("reset_rdata", rdata[k], 0);
        end
        Reset = 1'b0;
        @(negedge Clk);
        // Directed read: port 0, status register, fixed pad data.
        we0[0] = 1'b0; addr0[0] = 2'd3; wdata0[0] = 16'h0F0F; hpi_data_in[0] = 16'hA55A; req0[0] = 1'b1;
        txn(0, 1'b0, 0, 1'b1);
        chk("rdata_a55a", rdata[0], 16'hA55A);
        // Directed write: port 1, address register; rdata must not move.
        we1[0] = 1'b1; addr1[0] = 2'd2; wdata1[0] = 16'h1234; req1[0] = 1'b1;
        txn(0, 1'b0, 0, 1'b0);
        chk("rdata_after_write", rdata[0], 16'hA55A);
        // Both ports held high across four transactions.
        we0[0] = 1'b0; we1[0] = 1'b1; addr0[0] = 2'd1; addr1[0] = 2'd0;
        wdata0[0] = 16'hBEEF; wdata1[0] = 16'hCAFE;
        req0[0] = 1'b1; req1[0] = 1'b1;
        for (int i = 0; i < 4; i++) begin
`ifdef HPI_ARB_RR_EN
            chk("rr_order", pick(0), i % 2);
`else
            chk("fixed_order", pick(0), 0);
`endif
            txn(0, 1'b1, 0, 1'b0);
        end
        req0[0] = 1'b0; req1[0] = 1'b0;
        // Early drop of req0 during HOLD: one ack, no repeat.
        we0[0] = 1'b0; addr0[0] = 2'd0; req0[0] = 1'b1;
        txn(0, 1'b0, s_of(0) + 2, 1'b0);
        b = 0;
        repeat (10) begin
            @(negedge Clk);
            if (busy[0] || ack0[0]) b++;
        end
        chk("no_repeat", b, 0);
        // Reset in the first STROBE cycle.
        we0[0] = 1'b0; addr0[0] = 2'd3; req0[0] = 1'b1;
        b = 0;
        do begin
            @(negedge Clk);
            b++;
        end while (hpi_r[0] && b < 20);
        chk("reached_strobe", hpi_r[0], 0);
        #1 Reset = 1'b1;
        #1 chk("async_reset", {hpi_cs[0], hpi_r[0], hpi_w[0], busy[0], ack0[0], ack1[0]}, 6'b111000);
        chk("async_rdata", rdata[0], 0);
        @(negedge Clk);
        chk("reset_no_ack", {ack0[0], busy[0]}, 0);
        Reset = 1'b0;
        for (int k = 0; k < N; k++) begin
            exp_rdata[k] = 16'd0;
            last[k] = -1;
        end
        txn(0, 1'b0, 0, 1'b0);
        // Randomized traffic on all three timing configurations.
        rand_txns(0, 12);
        rand_txns(1, 8);
        rand_txns(2, 4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hpi_txn_sequencer.md
# hpi_txn_sequencer

Two-requester transaction sequencer and arbiter for the CY7C67200 HPI port. Each requester issues single 16-bit register/data-port reads or writes. The block arbitrates between the requesters and drives the chip-select, read and write strobes and the address with programmable setup, strobe and hold timing. It returns read data and a one-cycle acknowledge to the requester that issued the transaction. It sits between the CPU-side HPI register block plus the hardware USB poller, and the registered HPI pad interface.

## Interface
- STROBE_CYC, 2: cycles hpi_r/hpi_w held low; legal range 1–15.
- HOLD_CYC, 2: cycles after strobe with hpi_cs still low; legal range 2–15. The minimum of 2 covers the pad interface's one-cycle output and one-cycle input register stages.
- Clk  in  1  system clock.
- Reset  in  1  reset, asynchronous, active-high.
- req0, req1  in  1  transaction request from port 0 (CPU) and port 1 (poller); level, held until ack.
- we0, we1  in  1  1 = write, 0 = read; must be stable while req is high.
- addr0, addr1  in  2  HPI address: 0 data, 1 mailbox, 2 address, 3 status.
- wdata0, wdata1  in  16  write data; must be stable while req is high.
- ack0, ack1  out  1  one-cycle completion pulse.
- rdata  out  16  read data; valid in the ack cycle and held until the next read completes.
- busy  out  1  high from the grant cycle through the DONE state.
- gnt  out  1  port currently or most recently granted.
- hpi_address  out  2  to the pad interface.
- hpi_data_out  out  16  to the pad interface.
- hpi_r, hpi_w, hpi_cs  out  1  active-low strobes to the pad interface.
- hpi_data_in  in  16  registered pad data from the pad interface.

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, DONE.
- IDLE
  - All strobes are high.
  - If any req is high, arbitrate and latch the winner's we, addr and wdata into internal registers. Go to SETUP.
  - Latched values drive hpi_address and hpi_data_out until the next grant.
- SETUP (1 cycle): hpi_cs=0, hpi_r=hpi_w=1. Go to STROBE.
- STROBE (STROBE_CYC cycles): hpi_cs=0. hpi_w=0 if the latched we is 1, otherwise hpi_r=0. Go to HOLD.
- HOLD (HOLD_CYC cycles): hpi_cs=0, hpi_r=hpi_w=1.
  - For reads, rdata is registered from hpi_data_in on the edge ending HOLD cycle 1. That value was captured while the pad read strobe was still low.
  - Go to DONE.
- DONE (1 cycle): hpi_cs=1. Pulse ackN for the granted port. Go to IDLE.
- A single 4-bit down-counter times STROBE and HOLD. It loads CYC-1 on state entry and the state advances when the counter reaches 0.
- Arbitration: see Configuration. The losing request stays pending and is served on the next IDLE.
- Minimum transaction length: 3+STROBE_CYC+HOLD_CYC cycles, from the grant edge to the ack cycle inclusive.
- Back-to-back requests: one IDLE cycle always separates DONE from the next SETUP, so hpi_cs is high for at least 2 cycles between transactions.
- req deasserted mid-transaction: ignored. The transaction completes and the ack still pulses.
- req still high in the ack cycle: treated as a new request in the following IDLE. A requester must drop req on the ack edge to avoid a repeat.
- A write never updates rdata.

## Timing
- Reset values
  - State IDLE, counter 0.
  - hpi_cs=hpi_r=hpi_w=1, hpi_address=0, hpi_data_out=0.
  - ack0=ack1=0, rdata=0, busy=0, gnt=0, RR pointer=0.
- Reset asserted mid-transaction: all outputs return to reset values asynchronously. No ack is issued. The requester must re-issue the request after reset.
- All outputs are registered. Strobes reach the pins one cycle later through the pad interface register.
- busy rises on the edge that leaves IDLE and falls on the edge that leaves DONE.

## Configuration
- HPI_ARB_RR_EN defined: round-robin arbitration. On a simultaneous request, the port not granted last wins. The pointer updates on each grant.
- HPI_ARB_RR_EN undefined: fixed priority, port 0 always wins. The pointer logic is removed and port 1 can starve.

## Test plan
- Single read, defaults
  - Stimulus: req0 with we0=0, addr0=3; hpi_data_in=16'hA55A throughout HOLD.
  - Required: hpi_cs low for exactly 5 cycles and hpi_r low for 2; ack0 pulses 7 cycles after grant; rdata=16'hA55A.
- Single write
  - Stimulus: req1 with we1=1, addr1=2, wdata1=16'h1234.
  - Required: hpi_address=2 and hpi_data_out=16'h1234 stable from SETUP through HOLD; hpi_w low for 2 cycles; hpi_r stays 1; ack1 pulses; rdata unchanged.
- Simultaneous requests
  - Stimulus: req0 and req1 rise in the same cycle and stay high through 4 transactions.
  - Required with HPI_ARB_RR_EN: grants in order 0,1,0,1.
  - Required without HPI_ARB_RR_EN: grants in order 0,0,0,0 while port 1 is pending.
- Reset mid-transaction
  - Stimulus: assert Reset during STROBE cycle 1.
  - Required: hpi_cs, hpi_r and hpi_w go to 1 without waiting for a clock edge; no ack; busy=0. After Reset is released, a pending req0 gets a normal full transaction.
- Early request drop
  - Stimulus: drop req0 during HOLD.
  - Required: the transaction completes, ack0 pulses once, and no second transaction starts.
- Parameter sweep
  - Stimulus: STROBE_CYC=1, HOLD_CYC=2, then STROBE_CYC=15, HOLD_CYC=15.
  - Required: strobe widths are exactly 1 and 15 cycles, and the ack arrives at 3+S+H cycles after grant.
